wb_warmboot_ctrl: RTL

//  Wishbone slave that arms and triggers an iCE40 warm boot (SB_WARMBOOT image select).

---
 rtl/wb_warmboot_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wb_warmboot_ctrl.sv
// Warm-boot controller for the iCE40 SB_WARMBOOT primitive.
// Firmware arms it with a key write, then issues GO. After a programmable
// delay it raises a sticky boot request with the latched image select.
// The delay gives the USB DFU detach handshake time to complete first.
module wb_warmboot_ctrl #(
    parameter int unsigned DELAY_W     = 24,
    parameter int unsigned ARM_TIMEOUT = 65535,
    parameter logic [31:0] KEY         = 32'hB007CAFE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  wb_addr_i,
    output logic [31:0] wb_rdata_o,
    input  logic [31:0] wb_wdata_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        boot_now_o,
    output logic [1:0]  boot_sel_o
);

    // state   | meaning
    // IDLE    | disarmed, waiting for key
    // ARMED   | key accepted, waiting for GO (auto-disarms on timeout)
    // WAIT    | counting down the programmed delay
    // FIRE    | boot request asserted, only reset leaves
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FIRE  = 2'd3
    } state_t;

    localparam int unsigned      ARM_W    = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);

    state_t               state_q;
    logic [DELAY_W-1:0]   delay_q;
    logic [DELAY_W-1:0]   cnt_q;
    logic [ARM_W-1:0]     arm_cnt_q;
    logic [1:0]           sel_q;
    logic                 err_q;
    logic                 ack_q;
    logic [31:0]          rdata_q;
    logic                 boot_now_q;

    logic                 ack_d;
    logic                 err_d;
    logic [31:0]          rdata_d;
    logic [31:0]          rd_val;

    logic wr_stb, rd_stb;
    logic wr_csr, wr_dly, wr_key;
    logic key_ok, csr_go, csr_abort, csr_clr;
    logic in_fire, err_set, err_clr;

    // The strobe is only live on the first cycle of cyc, so each bus cycle
    // produces exactly one write or read action.
    assign wr_stb    = wb_cyc_i & wb_we_i & ~ack_q;
    assign rd_stb    = wb_cyc_i & ~wb_we_i & ~ack_q;
    assign wr_csr    = wr_stb & (wb_addr_i == 2'd0);
    assign wr_dly    = wr_stb & (wb_addr_i == 2'd1);
    assign wr_key    = wr_stb & (wb_addr_i == 2'd2);
    assign key_ok    = (wb_wdata_i == KEY);
    assign csr_go    = wb_wdata_i[2];
    assign csr_abort = wb_wdata_i[3];
    assign csr_clr   = wb_wdata_i[8];
    assign in_fire   = (state_q == ST_FIRE);

    // Once firing, the block is frozen: no write can raise or clear err.
    assign err_set = ~in_fire &
                     ((wr_key & ~key_ok) |
                      (wr_csr & csr_go & ((state_q == ST_IDLE) || (state_q == ST_WAIT))));
    assign err_clr = ~in_fire & wr_csr & csr_clr;
    assign err_d   = err_set | (err_q & ~err_clr);

    assign ack_d   = wb_cyc_i & ~ack_q;
    assign rdata_d = rd_stb ? rd_val : 32'd0;

    // Read mux; DELAY shows the live countdown while waiting.
    always_comb begin
        rd_val = 32'd0;
        case (wb_addr_i)
            2'd0: rd_val = {(state_q != ST_IDLE), 22'd0, err_q, 2'd0, state_q, 2'd0, sel_q};
            2'd1: rd_val = (state_q == ST_WAIT) ? 32'(cnt_q) : 32'(delay_q);
            default: rd_val = 32'd0;
        endcase
    end

    // Bus response, error flag and sequencing FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            delay_q    <= '0;
            cnt_q      <= '0;
            arm_cnt_q  <= '0;
            sel_q      <= 2'd0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
            boot_now_q <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            case (state_q)
                ST_IDLE: begin
                    if (wr_dly) delay_q <= wb_wdata_i[DELAY_W-1:0];
                    if (wr_key && key_ok) begin
                        state_q   <= ST_ARMED;
                        arm_cnt_q <= '0;
                    end
                end
                ST_ARMED: begin
                    if (wr_dly) delay_q <= wb_wdata_i[DELAY_W-1:0];
                    if (wr_csr && csr_abort) begin
                        state_q <= ST_IDLE;
                    end else if (wr_csr && csr_go) begin
                        state_q <= ST_WAIT;
                        sel_q   <= wb_wdata_i[1:0];
                        cnt_q   <= delay_q;
                    end else if (wr_key && key_ok) begin
                        arm_cnt_q <= '0;
                    end else if (arm_cnt_q == ARM_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        arm_cnt_q <= arm_cnt_q + ARM_W'(1);
                    end
                end
                ST_WAIT: begin
                    // Abort is honoured even on the cycle the count expires.
                    if (wr_csr && csr_abort) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q    <= ST_FIRE;
                        boot_now_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - DELAY_W'(1);
                    end
                end
                default: begin
                    boot_now_q <= 1'b1;
                end
            endcase
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_rdata_o = rdata_q;
    assign boot_now_o = boot_now_q;
    assign boot_sel_o = sel_q;

endmodule
